// File: rtl/arcade_input_ctrl.sv
// Player-input front end: ps2 key decode + joystick merge, registered outputs, stretched coin.
// Optional feature: define AUTOFIRE_EN for masked autofire on fire buttons.

module arcade_coin_fsm #(
  parameter int COIN_MIN_CYC = 100000
) (
  input  logic Clk,
  input  logic Rst_n,
  input  logic req,
  output logic coin
);
  localparam int CW = (COIN_MIN_CYC > 1) ? $clog2(COIN_MIN_CYC) : 1;

  typedef enum logic [1:0] {IDLE, PULSE, HOLD} st_t;

  st_t           st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      st_q  <= IDLE;
      cnt_q <= '0;
      req_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      req_q <= req;
    end
  end

  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    coin  = (st_q != IDLE);
    case (st_q)
      IDLE:  if (req && !req_q) begin
               st_d  = PULSE;
               cnt_d = CW'(COIN_MIN_CYC - 1);
             end
      PULSE: if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
             else             st_d  = req ? HOLD : IDLE;
      HOLD:  if (!req) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end
endmodule

module arcade_input_ctrl #(
  parameter int NUM_PLAYERS  = 2,
  parameter int NUM_FIRE     = 4,
  parameter int COIN_MIN_CYC = 100000,
  parameter int AUTOFIRE_DIV = 250000
) (
  input  logic                            Clk,
  input  logic                            Rst_n,
  input  logic [10:0]                     ps2_key,
  input  logic [16*NUM_PLAYERS-1:0]       joy,
  input  logic [NUM_FIRE-1:0]             autofire_mask,
  output logic [4*NUM_PLAYERS-1:0]        p_dir,
  output logic [NUM_FIRE*NUM_PLAYERS-1:0] p_fire,
  output logic [NUM_PLAYERS-1:0]          p_start,
  output logic [NUM_PLAYERS-1:0]          p_coin,
  output logic [3:0]                      any_dir,
  output logic [NUM_FIRE-1:0]             any_fire
);
  // key slot layout: [3:0] U,D,L,R  [7:4] F3..F0  [9:8] start pair  [11:10] coin pair
  localparam int NK = 12;

  logic [NUM_PLAYERS-1:0][15:0]          joy_w;
  logic [1:0][NK-1:0]                    key_q, hit;
  logic [NUM_PLAYERS-1:0][NK-1:0]        kst;
  logic                                  tog_q, ev;

  logic [NUM_PLAYERS-1:0][3:0]           dir_req, dir_q;
  logic [NUM_PLAYERS-1:0][NUM_FIRE-1:0]  fire_req, fire_gate, fire_q;
  logic [NUM_PLAYERS-1:0]                start_req, start_q, coin_req;
  logic                                  unused_bits;

  assign joy_w       = joy;
  assign ev          = ps2_key[10] != tog_q;
  assign unused_bits = ^{joy, autofire_mask, key_q};

  always_comb begin
    hit = '0;
    case (ps2_key[8:0])
      9'h175: hit[0][3]  = 1'b1;
      9'h172: hit[0][2]  = 1'b1;
      9'h16B: hit[0][1]  = 1'b1;
      9'h174: hit[0][0]  = 1'b1;
      9'h014: hit[0][4]  = 1'b1;
      9'h011: hit[0][5]  = 1'b1;
      9'h029: hit[0][6]  = 1'b1;
      9'h012: hit[0][7]  = 1'b1;
      9'h005: hit[0][8]  = 1'b1;
      9'h016: hit[0][9]  = 1'b1;
      9'h076: hit[0][10] = 1'b1;
      9'h02E: hit[0][11] = 1'b1;
      9'h02D: hit[1][3]  = 1'b1;
      9'h02B: hit[1][2]  = 1'b1;
      9'h023: hit[1][1]  = 1'b1;
      9'h034: hit[1][0]  = 1'b1;
      9'h01C: hit[1][4]  = 1'b1;
      9'h01B: hit[1][5]  = 1'b1;
      9'h015: hit[1][6]  = 1'b1;
      9'h01D: hit[1][7]  = 1'b1;
      9'h006: hit[1][8]  = 1'b1;
      9'h01E: hit[1][9]  = 1'b1;
      9'h036: hit[1][10] = 1'b1;
      default: hit = '0;
    endcase
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_pl
    if (p < 2) begin : g_kb
      assign kst[p] = key_q[p];
    end else begin : g_nokb
      assign kst[p] = '0;
    end

    assign dir_req[p] = kst[p][3:0] | joy_w[p][3:0];
    for (genvar f = 0; f < NUM_FIRE; f++) begin : g_fire
      if (f < 4) begin : g_kf
        assign fire_req[p][f] = kst[p][4+f] | joy_w[p][4+f];
      end else begin : g_jf
        assign fire_req[p][f] = joy_w[p][4+f];
      end
    end
    // both pad start bits count as this player's start
    assign start_req[p] = kst[p][8] | kst[p][9] | joy_w[p][8] | joy_w[p][9];
    assign coin_req[p]  = kst[p][10] | kst[p][11] | joy_w[p][10];

    arcade_coin_fsm #(.COIN_MIN_CYC(COIN_MIN_CYC)) u_coin (
      .Clk  (Clk),
      .Rst_n(Rst_n),
      .req  (coin_req[p]),
      .coin (p_coin[p])
    );
  end

`ifdef AUTOFIRE_EN
  localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

  logic [AW-1:0]                         af_cnt_q, af_cnt_d;
  logic                                  phase_q, phase_d, af_rise;
  logic [NUM_PLAYERS-1:0][NUM_FIRE-1:0]  af_req, af_req_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      af_cnt_q <= '0;
      phase_q  <= 1'b0;
      af_req_q <= '0;
    end else begin
      af_cnt_q <= af_cnt_d;
      phase_q  <= phase_d;
      af_req_q <= af_req;
    end
  end

  // gate with the next phase so a fresh press fires on its first cycle
  always_comb begin
    af_req   = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) af_req[p] = fire_req[p] & autofire_mask;
    af_rise  = |(af_req & ~af_req_q);
    af_cnt_d = af_cnt_q + 1'b1;
    phase_d  = phase_q;
    if (af_rise) begin
      af_cnt_d = '0;
      phase_d  = 1'b1;
    end else if (af_cnt_q == AW'(AUTOFIRE_DIV - 1)) begin
      af_cnt_d = '0;
      phase_d  = ~phase_q;
    end
    fire_gate = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      fire_gate[p] = fire_req[p] & (~autofire_mask | {NUM_FIRE{phase_d}});
  end
`else
  assign fire_gate = fire_req;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      tog_q   <= 1'b0;
      key_q   <= '0;
      dir_q   <= '0;
      fire_q  <= '0;
      start_q <= '0;
    end else begin
      tog_q   <= ps2_key[10];
      if (ev) key_q <= (key_q & ~hit) | (hit & {(2*NK){ps2_key[9]}});
      dir_q   <= dir_req;
      fire_q  <= fire_gate;
      start_q <= start_req;
    end
  end

  assign p_dir   = dir_q;
  assign p_fire  = fire_q;
  assign p_start = start_q;

  always_comb begin
    any_dir  = '0;
    any_fire = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      any_dir  = any_dir | dir_q[p];
      any_fire = any_fire | fire_q[p];
    end
  end
endmodule
